// File: rtl/led_panel_rx_if.sv
// led_panel_rx_if: panel link, frame readout port and status flags of led_panel_rx
//   master: panel driver / host side (drives serial link, readout address, err_clr)
//   slave : led_panel_rx side (receives link, returns rd_rgb and status)
interface led_panel_rx_if #(parameter int COLS = 32);
  logic red_in, green_in, blue_in;
  logic sclk_in, latch_in, blank_in;
  logic a_in, b_in;
  logic [1:0] rd_row;
  logic [$clog2(COLS)-1:0] rd_col;
  logic err_clr;
  logic [2:0] rd_rgb;
  logic latch_pulse;
  logic [1:0] latched_row;
  logic frame_done;
  logic blank_sync;
  logic len_err;
  logic blank_err;
  modport master (
    output red_in, green_in, blue_in, sclk_in, latch_in, blank_in, a_in, b_in,
    output rd_row, rd_col, err_clr,
    input  rd_rgb, latch_pulse, latched_row, frame_done, blank_sync, len_err, blank_err
  );
  modport slave (
    input  red_in, green_in, blue_in, sclk_in, latch_in, blank_in, a_in, b_in,
    input  rd_row, rd_col, err_clr,
    output rd_rgb, latch_pulse, latched_row, frame_done, blank_sync, len_err, blank_err
  );
endinterface

// File: rtl/led_panel_rx.sv
// led_panel_rx: HUB panel link receiver capturing shifted rows into a 4 x COLS RGB frame store
//   clk, reset (async, active-high)
//   bus.slave: red/green/blue/sclk/latch/blank/a/b panel inputs (asynchronous),
//              rd_row/rd_col -> rd_rgb (1-cycle registered read), err_clr,
//              latch_pulse, latched_row, frame_done, blank_sync, len_err, blank_err
//   LED_PANEL_RX_BLANK_CHECK_EN: when defined, a latch while the display is enabled sets blank_err
module led_panel_rx #(
  parameter int COLS = 32
) (
  input logic clk,
  input logic reset,
  led_panel_rx_if.slave bus
);
  localparam int CW = $clog2(COLS + 1) + 1;
  // synchroniser bit map: 0 red, 1 green, 2 blue, 3 sclk, 4 latch, 5 blank, 6 a, 7 b
  logic [7:0] pin, s1, s2;
  logic [1:0] s3;
  logic sclk_rise, latch_rise, len_bad, rd_ok;
  logic [1:0] row_s;
  logic [CW-1:0] bit_cnt, cnt_nx;
  logic [2:0][COLS-1:0] sr, sh;
  logic [3:0][2:0][COLS-1:0] st;
  logic [2:0] rd_rgb_q;
  logic latch_pulse_q, frame_done_q, len_err_q;
  logic [1:0] latched_row_q;
  assign pin = {bus.b_in, bus.a_in, bus.blank_in, bus.latch_in, bus.sclk_in,
                bus.blue_in, bus.green_in, bus.red_in};
  assign sclk_rise = s2[3] & ~s3[0];
  assign latch_rise = s2[4] & ~s3[1];
  assign row_s = s2[7:6];
  // a same-cycle latch commits the post-shift row and checks the post-shift count
  assign sh = sclk_rise ? {sr[2][COLS-2:0], s2[2], sr[1][COLS-2:0], s2[1], sr[0][COLS-2:0], s2[0]} : sr;
  assign cnt_nx = (sclk_rise && bit_cnt != '1) ? bit_cnt + 1'b1 : bit_cnt;
  assign len_bad = cnt_nx != CW'(COLS);
  assign rd_ok = 32'(bus.rd_col) < 32'(COLS);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      sr <= '0;
      st <= '0;
      bit_cnt <= '0;
      rd_rgb_q <= '0;
      latch_pulse_q <= 1'b0;
      frame_done_q <= 1'b0;
      latched_row_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= {s2[4], s2[3]};
      sr <= sh;
      bit_cnt <= latch_rise ? '0 : cnt_nx;
      if (latch_rise) st[row_s] <= sh;
      latched_row_q <= latch_rise ? row_s : latched_row_q;
      latch_pulse_q <= latch_rise;
      frame_done_q <= latch_rise && row_s == 2'd3;
      len_err_q <= (latch_rise & len_bad) | (len_err_q & ~bus.err_clr);
      // reads see the store before this cycle's commit
      rd_rgb_q <= rd_ok ? {st[bus.rd_row][0][bus.rd_col], st[bus.rd_row][1][bus.rd_col],
                           st[bus.rd_row][2][bus.rd_col]} : 3'b000;
    end
  end
`ifdef LED_PANEL_RX_BLANK_CHECK_EN
  logic blank_err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) blank_err_q <= 1'b0;
    else blank_err_q <= (latch_rise & ~s2[5]) | (blank_err_q & ~bus.err_clr);
  end
  assign bus.blank_err = blank_err_q;
`else
  assign bus.blank_err = 1'b0;
`endif
  assign bus.rd_rgb = rd_rgb_q;
  assign bus.latch_pulse = latch_pulse_q;
  assign bus.latched_row = latched_row_q;
  assign bus.frame_done = frame_done_q;
  assign bus.blank_sync = s2[5];
  assign bus.len_err = len_err_q;
endmodule

// File: tb/tb_led_panel_rx.sv
// tb_led_panel_rx: randomized scoreboard bench for led_panel_rx against a bit-history frame model
module tb_led_panel_rx;
  localparam int COLS = 32;
  typedef struct {
    logic [1:0] row;
    logic fd;
    logic le;
    logic be;
  } commit_t;
  logic clk = 1'b0;
  logic reset;
  logic rd_act = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [2:0] m_store[4][COLS];
  logic [2:0] hist[$];
  int m_cnt = 0;
  logic m_len = 1'b0;
  logic m_blank = 1'b0;
  logic [1:0] cur_row = 2'd0;
  logic blank_v = 1'b1;
  commit_t cq[$];
  logic [2:0] rq[$];
  always #5 clk = ~clk;
  led_panel_rx_if #(.COLS(COLS)) bus();
  led_panel_rx #(.COLS(COLS)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic model_reset();
    hist.delete();
    m_cnt = 0;
    m_len = 1'b0;
    m_blank = 1'b0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < COLS; c++) m_store[r][c] = 3'b000;
  endtask
  // column c of a committed row holds the bit sent c shifts before the latch
  task automatic model_commit(bit clr);
    logic bad;
    bad = m_cnt != COLS;
    m_len = bad | (clr ? 1'b0 : m_len);
`ifdef LED_PANEL_RX_BLANK_CHECK_EN
    m_blank = ~blank_v | (clr ? 1'b0 : m_blank);
`else
    m_blank = 1'b0;
`endif
    for (int c = 0; c < COLS; c++)
      m_store[cur_row][c] = (c < hist.size()) ? hist[hist.size() - 1 - c] : 3'b000;
    m_cnt = 0;
    cq.push_back('{cur_row, cur_row == 2'd3, m_len, m_blank});
  endtask
  task automatic set_row(logic [1:0] r);
    cur_row = r;
    bus.a_in = r[0];
    bus.b_in = r[1];
    tick(3);
  endtask
  task automatic set_blank(logic b);
    blank_v = b;
    bus.blank_in = b;
    tick(3);
  endtask
  task automatic send_bit(logic [2:0] rgb, bit with_latch = 0);
    hist.push_back(rgb);
    m_cnt++;
    if (with_latch) model_commit(0);
    {bus.red_in, bus.green_in, bus.blue_in} = rgb;
    tick(3);
    bus.sclk_in = 1'b1;
    if (with_latch) bus.latch_in = 1'b1;
    tick(3);
    bus.sclk_in = 1'b0;
    bus.latch_in = 1'b0;
    tick(3);
  endtask
  task automatic send_rand(int n);
    for (int i = 0; i < n; i++) send_bit(3'($urandom_range(0, 7)));
  endtask
  task automatic latch(bit clr = 0);
    model_commit(clr);
    bus.latch_in = 1'b1;
    bus.err_clr = clr;
    tick(3);
    bus.latch_in = 1'b0;
    bus.err_clr = 1'b0;
    tick(3);
  endtask
  task automatic clr_err();
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    m_len = 1'b0;
    m_blank = 1'b0;
    tick(1);
  endtask
  task automatic read_exp(int r, int c, logic [2:0] e);
    rq.push_back(e);
    bus.rd_row = 2'(r);
    bus.rd_col = 5'(c);
    rd_act = 1'b1;
    tick(1);
    rd_act = 1'b0;
  endtask
  task automatic read(int r, int c);
    read_exp(r, c, m_store[r][c]);
  endtask
  task automatic read_row(int r);
    for (int c = 0; c < COLS; c++) read(r, c);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask
  initial begin : monitor
    logic ra;
    commit_t c;
    logic [2:0] e;
    forever begin
      @(posedge clk);
      ra = rd_act;
      #1;
      if (ra) begin
        if (rq.size() == 0) chk("rd_unexpected", ra, 1'b0);
        else begin
          e = rq.pop_front();
          chk("rd_rgb", bus.rd_rgb, e);
        end
      end
      if (bus.latch_pulse) begin
        if (cq.size() == 0) chk("latch_pulse_spurious", bus.latch_pulse, 1'b0);
        else begin
          c = cq.pop_front();
          chk("latched_row", bus.latched_row, c.row);
          chk("frame_done", bus.frame_done, c.fd);
          chk("len_err", bus.len_err, c.le);
          chk("blank_err", bus.blank_err, c.be);
        end
      end else chk("frame_done_alone", bus.frame_done, 1'b0);
    end
  end
  initial begin
    reset = 1'b1;
    {bus.red_in, bus.green_in, bus.blue_in, bus.sclk_in, bus.latch_in} = '0;
    bus.blank_in = 1'b1;
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    bus.rd_row = '0;
    bus.rd_col = '0;
    bus.err_clr = 1'b0;
    model_reset();
    tick(3);
    chk("rst_rd_rgb", bus.rd_rgb, 3'b000);
    chk("rst_latch_pulse", bus.latch_pulse, 1'b0);
    chk("rst_latched_row", bus.latched_row, 2'd0);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    chk("rst_blank_sync", bus.blank_sync, 1'b0);
    chk("rst_len_err", bus.len_err, 1'b0);
    chk("rst_blank_err", bus.blank_err, 1'b0);
    reset = 1'b0;
    tick(3);
    chk("blank_sync_follow", bus.blank_sync, 1'b1);
    for (int r = 0; r < 4; r++) for (int c = 0; c < COLS; c++) read_exp(r, c, 3'b000);
    // single red bit travels to the far column
    set_row(2);
    send_bit(3'b100);
    for (int i = 1; i < COLS; i++) send_bit(3'b000);
    latch();
    read_exp(2, COLS - 1, 3'b100);
    read_exp(2, 0, 3'b000);
    read_row(2);
    // full random frame
    for (int r = 0; r < 4; r++) begin
      set_row(2'(r));
      send_rand(COLS);
      latch();
    end
    for (int r = 0; r < 4; r++) read_row(r);
    // length errors and clear priority
    set_row(1);
    send_rand(COLS - 1);
    latch();
    chk("len_err_short", bus.len_err, 1'b1);
    clr_err();
    chk("len_err_cleared", bus.len_err, 1'b0);
    send_rand(COLS + 1);
    latch(1);
    chk("len_err_set_wins", bus.len_err, 1'b1);
    clr_err();
    chk("len_err_cleared2", bus.len_err, 1'b0);
    read_row(1);
    // last bit and latch on the same edge
    set_row(3);
    send_rand(COLS - 1);
    send_bit(3'($urandom_range(0, 7)), 1);
    chk("len_err_same_edge", bus.len_err, 1'b0);
    read_row(3);
    // reset mid-row
    set_row(0);
    send_rand(10);
    do_reset();
    for (int r = 0; r < 4; r++) read_row(r);
    tick(3);
    send_rand(COLS);
    latch();
    chk("len_err_after_reset", bus.len_err, 1'b0);
    read_row(0);
    // blank check
    set_blank(1'b0);
    set_row(1);
    send_rand(COLS);
    latch();
`ifdef LED_PANEL_RX_BLANK_CHECK_EN
    chk("blank_err_set", bus.blank_err, 1'b1);
`else
    chk("blank_err_off", bus.blank_err, 1'b0);
`endif
    clr_err();
    set_blank(1'b1);
    send_rand(COLS);
    latch();
    chk("blank_err_quiet", bus.blank_err, 1'b0);
    for (int i = 0; i < 40; i++) read($urandom_range(0, 3), $urandom_range(0, COLS - 1));
    tick(5);
    chk("commit_q_drained", cq.size(), 0);
    chk("read_q_drained", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_panel_rx.md
# led_panel_rx

Receiver and frame capture for the HUB-style LED panel drive interface: red/green/blue serial data, sclk, latch, blank and 2-bit row address a/b. The block oversamples the panel-side signals with the system clock and shifts column data per sclk rising edge. On each latch rising edge it commits the shifted row into a 4-row × COLS frame store, which can then be read back through a registered port. It sits on the opposite end of the panel link from the panel driver and serves as an on-chip loopback checker and panel emulator.

## Interface
- COLS, 32, columns per row; must be ≥ 2 (sets shift length and store width).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- red_in, green_in, blue_in  in  1 each  serial colour data, asynchronous to clk.
- sclk_in  in  1  shift clock, asynchronous; active edge is rising.
- latch_in  in  1  row latch, asynchronous; active edge is rising.
- blank_in  in  1  panel blank, asynchronous; 1 = display off.
- a_in, b_in  in  1 each  row address, asynchronous; row = {b_in, a_in}.
- rd_row  in  2  readout row.
- rd_col  in  $clog2(COLS)  readout column; values ≥ COLS return 0.
- err_clr  in  1  synchronous clear of sticky error flags.
- rd_rgb  out  3  {red, green, blue} at (rd_row, rd_col), registered.
- latch_pulse  out  1  one-cycle strobe when a row is committed.
- latched_row  out  2  row index of the last commit.
- frame_done  out  1  one-cycle strobe, coincident with latch_pulse when the committed row is 3.
- blank_sync  out  1  synchronised blank_in.
- len_err  out  1  sticky: a latch arrived with bit count ≠ COLS.
- blank_err  out  1  sticky; only present/meaningful per Configuration, otherwise tied 0.

## Operation
- All eight panel inputs pass through a 2-flop synchroniser (s1→s2), plus a third flop (s3) on sclk and latch for edge detection. rise = s2 & ~s3.
- sclk rise: the three colour shift registers shift by one. The new bit enters at column 0, existing bits move toward COLS-1. After COLS shifts, the first bit sent is at column COLS-1. bit_cnt increments and saturates at its all-ones value (width $clog2(COLS+1)+1).
- latch rise: shift-register contents are copied into store row {b_s2, a_s2}, and latched_row updates to that row. latch_pulse=1 for one cycle. If bit_cnt ≠ COLS, len_err is set. bit_cnt clears to 0. Shift registers are not cleared.
- sclk rise and latch rise in the same cycle: the shift happens first. The committed row includes the new bit, and the length check uses bit_cnt+1.
- Readout: rd_rgb is registered from the store. If a read and a commit to the same row occur in the same cycle, the read returns the pre-commit value.
- err_clr clears len_err/blank_err. If a set condition occurs in the same cycle, set wins.
- Reset mid-row: the partial shift is discarded, the store is zeroed, bit_cnt=0, and no pulse is generated.

## Timing
- Reset values: rd_rgb=0, latch_pulse=0, latched_row=0, frame_done=0, blank_sync=0, len_err=0, blank_err=0. All synchroniser flops are 0 after reset.
- Edge latency: an input change sampled at clk edge k produces the shift or commit at edge k+2. latch_pulse and frame_done are high during cycle k+2..k+3. Updated latched_row is visible after edge k+2.
- The colour bits used for a shift are the s2 values at the same edge, so data pass through the same synchroniser depth as sclk.
- Input requirements: sclk_in and latch_in each high ≥3 clk and low ≥3 clk. Data and a/b stable from ≥3 clk before to ≥1 clk after the active edge. Violations cause undefined capture but never a lockup.
- Read latency: 1 cycle from rd_row/rd_col to rd_rgb.
- blank_sync lags blank_in by 2 cycles.

## Configuration
- LED_PANEL_RX_BLANK_CHECK_EN defined: a latch rise while blank_sync=0 (display enabled during latch) sets sticky blank_err. The commit still occurs.
- Not defined: no check logic is built and blank_err is constant 0.

## Test plan
- Reset → all outputs 0. Read every (row, col) → rd_rgb=3'b000.
- Row 2 (a=0, b=1): shift 32 bits, red=1 only on the first bit, then latch. Expect latch_pulse once, latched_row=2, frame_done=0, len_err=0. Reading (2, 31) → 3'b100 and (2, 0) → 3'b000.
- Rows 0..3 with distinct patterns, latch after each. Expect frame_done only on the row-3 commit, and all four rows read back intact.
- Latch after 31 sclk rises → len_err=1. Assert err_clr → 0. Then err_clr coincident with a 33-bit latch → len_err stays 1.
- sclk and latch rising on the same cycle as the 32nd bit → commit contains all 32 bits and len_err=0. Separately, assert reset after 10 shifts → store zeroed, and a subsequent full 32-bit row commits cleanly.
- With the macro defined: latch with blank_in=0 → blank_err=1. Latch with blank_in=1 → no change. Without the macro, blank_err stays 0.
